// File: rtl/state_sequencer_pkg.sv
// Shared state encoding and opcodes for the control-unit sequencer and decoder.
package state_sequencer_pkg;

    localparam int unsigned GRP_W   = 7;
    localparam int unsigned STP_W   = 5;
    localparam int unsigned STATE_W = GRP_W + STP_W;
    localparam int unsigned OPC_W   = 4;

    // Group bit indices within the grp field
    localparam int unsigned GRP_R    = 6;
    localparam int unsigned GRP_F    = 5;
    localparam int unsigned GRP_MOV  = 4;
    localparam int unsigned GRP_LD   = 3;
    localparam int unsigned GRP_ST   = 2;
    localparam int unsigned GRP_HALT = 1;
    localparam int unsigned GRP_ILL  = 0;

    localparam logic [OPC_W-1:0] OP_MOV  = 4'h1;
    localparam logic [OPC_W-1:0] OP_LD   = 4'h2;
    localparam logic [OPC_W-1:0] OP_ST   = 4'h3;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    // One-hot group and step fields positioned inside the 12-bit state code
    localparam logic [STATE_W-1:0] G_R    = STATE_W'(1) << (STP_W + GRP_R);
    localparam logic [STATE_W-1:0] G_F    = STATE_W'(1) << (STP_W + GRP_F);
    localparam logic [STATE_W-1:0] G_MOV  = STATE_W'(1) << (STP_W + GRP_MOV);
    localparam logic [STATE_W-1:0] G_LD   = STATE_W'(1) << (STP_W + GRP_LD);
    localparam logic [STATE_W-1:0] G_ST   = STATE_W'(1) << (STP_W + GRP_ST);
    localparam logic [STATE_W-1:0] G_HALT = STATE_W'(1) << (STP_W + GRP_HALT);
    localparam logic [STATE_W-1:0] G_ILL  = STATE_W'(1) << (STP_W + GRP_ILL);
    localparam logic [STATE_W-1:0] P0     = STATE_W'(1);
    localparam logic [STATE_W-1:0] P1     = STATE_W'(2);
    localparam logic [STATE_W-1:0] P2     = STATE_W'(4);
    localparam logic [STATE_W-1:0] P3     = STATE_W'(8);
    localparam logic [STATE_W-1:0] P4     = STATE_W'(16);

    typedef enum logic [STATE_W-1:0] {
        S_R    = G_R    | P0,
        S_F0   = G_F    | P0,
        S_F1   = G_F    | P1,
        S_F2   = G_F    | P2,
        S_MOV0 = G_MOV  | P0,
        S_LD0  = G_LD   | P0,
        S_LD1  = G_LD   | P1,
        S_LD2  = G_LD   | P2,
        S_LD3  = G_LD   | P3,
        S_LD4  = G_LD   | P4,
        S_ST0  = G_ST   | P0,
        S_ST1  = G_ST   | P1,
        S_ST2  = G_ST   | P2,
        S_ST3  = G_ST   | P3,
        S_ST4  = G_ST   | P4,
        S_HALT = G_HALT | P0,
        S_ILL  = G_ILL  | P0
    } state_t;

    // Final execute step of each instruction; end_sq is expected here
    function automatic logic is_last_step(state_t s);
        return (s == S_MOV0) || (s == S_LD4) || (s == S_ST4) || (s == S_HALT);
    endfunction

    // Same group, one-hot step shifted up by one
    function automatic state_t next_step(state_t s);
        return state_t'({s[STATE_W-1:STP_W], s[STP_W-2:0], 1'b0});
    endfunction

endpackage

// File: rtl/state_sequencer_retire_counter.sv
// Retired-instruction counter: enable-increment, wraps, async active-low clear.
module retire_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Count one per enabled cycle, wrapping from all-ones to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/state_sequencer.sv
// Control-unit sequencer: reset, fetch and execute steps with monitor run/step control.
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rd,
    input  logic               end_sq,
    input  logic               pause_cc,
    input  logic               run,
    input  logic               step,
    output logic [STATE_W-1:0] state,
    output logic               stopped,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retire_cnt
);

    localparam int unsigned       RCNT_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);

    state_t            state_q;
    logic [RCNT_W-1:0] rst_cnt;
    logic              gate_c;
    logic              exec_c;
    logic              retire_en_c;
    logic              unused_rd_low;

    // Instruction boundary gate and retire qualification
    always_comb begin
        gate_c      = run | step;
        // MOV, LD, ST and HALT group bits are contiguous in the state code
        exec_c      = |state_q[STP_W + GRP_HALT +: 4];
        retire_en_c = exec_c & ~pause_cc & end_sq;
    end

    assign unused_rd_low = ^rd[3:0];

    // Sequencer state, reset-delay counter and illegal pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_R;
            rst_cnt <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state_q)
                S_R: begin
                    if (rst_cnt == RCNT_LAST) begin
                        state_q <= S_F0;
                    end else begin
                        rst_cnt <= rst_cnt + RCNT_W'(1);
                    end
                end
                S_F0: begin
                    if (gate_c) begin
                        state_q <= S_F1;
                    end
                end
                S_F1: state_q <= S_F2;
                S_F2: begin
                    case (rd[7:4])
                        OP_MOV:  state_q <= S_MOV0;
                        OP_LD:   state_q <= S_LD0;
                        OP_ST:   state_q <= S_ST0;
                        OP_HALT: state_q <= S_HALT;
                        default: state_q <= S_ILL;
                    endcase
                end
                S_ILL: begin
                    state_q <= S_F0;
                    illegal <= 1'b1;
                end
                default: begin
                    if (pause_cc) begin
                        state_q <= state_q;
                    end else if (end_sq) begin
                        state_q <= S_F0;
                    end else if (is_last_step(state_q)) begin
                        state_q <= S_F0;
                        illegal <= 1'b1;
                    end else begin
                        state_q <= next_step(state_q);
                    end
                end
            endcase
        end
    end

    assign state   = state_q;
    assign halted  = state_q[STP_W + GRP_HALT];
    assign stopped = (state_q == S_F0) & ~gate_c;

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire_en_c),
        .cnt   (retire_cnt)
    );

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: instruction-level model plus directed scenarios.
module tb_state_sequencer;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [7:0]  rd       = 8'h15;
    logic        end_sq   = 1'b1;
    logic        pause_cc = 1'b0;
    logic        run      = 1'b1;
    logic        step     = 1'b0;

    logic [11:0] state, state_w;
    logic        stopped, halted, illegal;
    logic        stopped_w, halted_w, illegal_w;
    logic [15:0] retire_cnt;
    logic [2:0]  retire_cnt_w;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    state_sequencer #(.RESET_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rd(rd), .end_sq(end_sq), .pause_cc(pause_cc),
        .run(run), .step(step), .state(state), .stopped(stopped), .halted(halted),
        .illegal(illegal), .retire_cnt(retire_cnt)
    );

    // Narrow-counter instance so the wrap is reached in a few instructions
    state_sequencer #(.RESET_CYCLES(2), .CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .rd(rd), .end_sq(end_sq), .pause_cc(pause_cc),
        .run(run), .step(step), .state(state_w), .stopped(stopped_w), .halted(halted_w),
        .illegal(illegal_w), .retire_cnt(retire_cnt_w)
    );

    // Model: group index (6 R,5 F,4 MOV,3 LD,2 ST,1 HALT,0 ILL) and step number
    typedef struct {
        int          grp;
        int          stp;
        int          rcnt;
        logic        ill;
        logic [15:0] ret;
    } mdl_t;

    mdl_t m;

    function automatic int exec_len(input int g);
        case (g)
            3, 2:    return 5;
            default: return 1;
        endcase
    endfunction

    function automatic mdl_t model_next(input mdl_t c);
        mdl_t n = c;
        n.ill = 1'b0;
        if (c.grp == 6) begin
            n.rcnt = c.rcnt + 1;
            if (n.rcnt == 2) begin n.grp = 5; n.stp = 0; end
        end else if (c.grp == 5) begin
            if (c.stp == 0) begin
                if (run || step) n.stp = 1;
            end else if (c.stp == 1) begin
                n.stp = 2;
            end else begin
                n.stp = 0;
                case (rd[7:4])
                    4'h1:    n.grp = 4;
                    4'h2:    n.grp = 3;
                    4'h3:    n.grp = 2;
                    4'hF:    n.grp = 1;
                    default: n.grp = 0;
                endcase
            end
        end else if (c.grp == 0) begin
            n.grp = 5; n.stp = 0; n.ill = 1'b1;
        end else if (!pause_cc) begin
            if (end_sq) begin
                n.ret = c.ret + 16'd1; n.grp = 5; n.stp = 0;
            end else if (c.stp == exec_len(c.grp) - 1) begin
                n.grp = 5; n.stp = 0; n.ill = 1'b1;
            end else begin
                n.stp = c.stp + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{grp: 6, stp: 0, rcnt: 0, ill: 1'b0, ret: 16'd0};
        else        m <= model_next(m);
    end

    function automatic logic [11:0] exp_state();
        return (12'd1 << (5 + m.grp)) | (12'd1 << m.stp);
    endfunction

    function automatic logic exp_stopped();
        return (m.grp == 5) && (m.stp == 0) && !(run || step);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state",     16'(state),        16'(exp_state()));
            check("halted",    16'(halted),       16'(m.grp == 1));
            check("illegal",   16'(illegal),      16'(m.ill));
            check("stopped",   16'(stopped),      16'(exp_stopped()));
            check("retire",    retire_cnt,        m.ret);
            check("state_w",   16'(state_w),      16'(exp_state()));
            check("halted_w",  16'(halted_w),     16'(m.grp == 1));
            check("illegal_w", 16'(illegal_w),    16'(m.ill));
            check("stopped_w", 16'(stopped_w),    16'(exp_stopped()));
            check("retire_w",  16'(retire_cnt_w), 16'(m.ret[2:0]));
        end
    end

    // Advance until the model reaches grp/stp, then return just after a falling edge
    task automatic goto(input int g, input int s, input int budget);
        int n = 0;
        while (!(m.grp == g && m.stp == s)) begin
            if (n == budget) begin
                check($sformatf("goto_g%0d_s%0d", g, s), 16'(m.grp * 16 + m.stp), 16'(g * 16 + s));
                return;
            end
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic next_cyc();
        @(negedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);

        // Reset release: two cycles in R, then F0 and a MOV
        @(posedge clk); #1 rst_n = 1'b1;
        next_cyc();
        check("rst_r0",      16'(state), 16'h0801);
        check("rst_halted",  16'(halted), 16'd0);
        check("rst_illegal", 16'(illegal), 16'd0);
        check("rst_stopped", 16'(stopped), 16'd0);
        check("rst_retire",  retire_cnt, 16'd0);
        next_cyc(); check("rst_r1", 16'(state), 16'h0801);
        next_cyc(); check("f0",     16'(state), 16'h0401);
        next_cyc(); check("f1",     16'(state), 16'h0402);
        next_cyc(); check("f2",     16'(state), 16'h0404);
        next_cyc(); check("mov0",   16'(state), 16'h0201);
        next_cyc(); check("mov_f0", 16'(state), 16'h0401);
        check("mov_retire", retire_cnt, 16'd1);

        // LD with end_sq only at the last step
        rd = 8'h21; end_sq = 1'b0;
        goto(3, 4, 10);
        check("ld4", 16'(state), 16'h0110);
        end_sq = 1'b1;
        goto(5, 0, 4);
        check("ld_retire",  retire_cnt, 16'd2);
        check("ld_illegal", 16'(illegal), 16'd0);

        // ST missing end_sq at ST4
        rd = 8'h30; end_sq = 1'b0;
        goto(2, 4, 10);
        check("st4", 16'(state), 16'h0090);
        goto(5, 0, 4);
        check("st_illegal", 16'(illegal), 16'd1);
        check("st_retire",  retire_cnt, 16'd2);

        // Illegal opcode
        rd = 8'h70;
        goto(0, 0, 6);
        check("ill",         16'(state), 16'h0021);
        check("ill_no_puls", 16'(illegal), 16'd0);
        next_cyc();
        check("ill_f0",      16'(state), 16'h0401);
        check("ill_pulse",   16'(illegal), 16'd1);
        check("ill_retire",  retire_cnt, 16'd2);

        // Stop at F0, single-step one MOV, step during F1 ignored
        run = 1'b0; rd = 8'h15; end_sq = 1'b1;
        repeat (3) next_cyc();
        check("stop_state",   16'(state), 16'h0401);
        check("stop_flag",    16'(stopped), 16'd1);
        step = 1'b1; #1;
        check("step_gate",    16'(stopped), 16'd0);
        @(posedge clk); #1 step = 1'b0;
        check("step_f1",      16'(state), 16'h0402);
        step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        check("step_f2",      16'(state), 16'h0404);
        goto(5, 0, 4);
        check("step_retire",  retire_cnt, 16'd3);
        repeat (4) next_cyc();
        check("restop_state", 16'(state), 16'h0401);
        check("restop_flag",  16'(stopped), 16'd1);
        check("restop_ret",   retire_cnt, 16'd3);

        // Free-run five MOVs; narrow counter wraps 7 -> 0
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            goto(4, 0, 8);
            goto(5, 0, 8);
        end
        check("wrap_retire",   retire_cnt, 16'd8);
        check("wrap_retire_w", 16'(retire_cnt_w), 16'd0);

        // HALT held by pause_cc, left only by reset
        rd = 8'hFF; end_sq = 1'b1; pause_cc = 1'b1;
        goto(1, 0, 6);
        repeat (20) next_cyc();
        check("halt_state",  16'(state), 16'h0041);
        check("halt_flag",   16'(halted), 16'd1);
        check("halt_retire", retire_cnt, 16'd8);
        rst_n = 1'b0; #1;
        check("async_rst_state",  16'(state), 16'h0801);
        check("async_rst_halted", 16'(halted), 16'd0);
        check("async_rst_retire", retire_cnt, 16'd0);

        // Recover and retire one MOV after reset
        pause_cc = 1'b0; rd = 8'h15;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        goto(4, 0, 10);
        goto(5, 0, 6);
        check("post_rst_retire", retire_cnt, 16'd1);
        repeat (2) next_cyc();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Control-unit state machine that produces the 12-bit `state` code consumed by the instruction decoder.
- Consumes the decoder's end_sq and pause_cc, plus the memory read data during fetch.
- Walks reset, fetch, and the per-instruction execute steps.
- Adds monitor-facing run/step control, a halt flag and a retired-instruction counter for the debug monitor.

Parameters:
- RESET_CYCLES, 2, cycles spent in R after reset release before entering F0 (must be >=1).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd  input  8  memory read data; opcode source in F2 (same value being loaded into I).
- end_sq  input  1  decoder: current step is last of instruction.
- pause_cc  input  1  decoder: hold current state.
- run  input  1  monitor: 1 = free-run, 0 = stop at next instruction boundary.
- step  input  1  monitor: single-cycle pulse; when stopped, execute exactly one instruction.
- state  output  12  current state code (encoding from shared package).
- stopped  output  1  1 while held in F0 by run=0.
- halted  output  1  1 while in HALT.
- illegal  output  1  one-cycle pulse on illegal opcode or missing end_sq.
- retire_cnt  output  CNT_W  instructions completed, wraps modulo 2^CNT_W.

Behaviour:
- State encoding: state = {grp[6:0], stp[4:0]}, both one-hot.
  - grp bits: 6 R, 5 F, 4 MOV, 3 LD, 2 ST, 1 HALT, 0 ILL.
  - stp bit n = step n.
  - Examples: F2 = grp F, stp 2; LD4 = grp LD, stp 4.
- Reset (rst_n=0, async):
  - state=R; reset counter=0; stopped=0; halted=0; illegal=0; retire_cnt=0.
  - Reset asserted mid-instruction aborts immediately.
- R: count RESET_CYCLES cycles, then go to F0.
- Fetch:
  - F0: if the boundary gate is open, go to F1; otherwise hold F0 with stopped=1.
    - Gate open = run=1, or step=1 sampled this cycle.
    - A step pulse arriving while not stopped is ignored (not queued).
  - F1 -> F2 unconditionally.
  - F2 dispatches on rd[7:4]: 0x1 -> MOV0; 0x2 -> LD0; 0x3 -> ST0; 0xF -> HALT; any other -> ILL.
- Execute:
  - LDn -> LDn+1 for n<4; STn -> STn+1 for n<4.
  - MOV0, LD4 and ST4 expect end_sq=1.
- Next-state priority, highest first, evaluated every cycle outside R/F0/F1/F2:
  1. pause_cc=1: hold current state. This covers HALT, where end_sq=1 and pause_cc=1; HALT is exited only by reset.
  2. end_sq=1: go to F0 and increment retire_cnt.
  3. Last step reached without end_sq (MOV0, LD4, ST4; e.g. decoder rejects register field 00): go to F0, pulse illegal, no retire increment.
  4. Otherwise: advance to the next step.
- ILL: next cycle goes to F0 and pulses illegal for that one cycle; retire_cnt is unchanged.
- halted = (grp==HALT), registered with state.
- stopped = (state==F0) & ~gate.
- Both are combinational from state and inputs, and glitch-free relative to clk.
- retire_cnt wraps from all-ones to 0 without saturation.
- Latency: MOV = 4 cycles F0..MOV0; LD and ST = 8 cycles each.
- run deasserted mid-instruction has no effect until the next F0.

Decomposition:
- Shared package (state.v include):
  - The state_* 12-bit constants.
  - grp/stp bit-index defines.
  - Opcode defines OP_MOV=4'h1, OP_LD=4'h2, OP_ST=4'h3, OP_HALT=4'hF.
  - The decoder uses the same include.
- One natural sub-module: retire_counter (CNT_W-wide enable-increment counter with async active-low clear).
- Next-state logic stays in state_sequencer.

Test Plan:
- Reset, RESET_CYCLES=2, run=1 -> state=R for 2 cycles after rst_n rises, then F0; all outputs 0.
- rd=8'h15 at F2, end_sq=1 in MOV0 -> F0,F1,F2,MOV0,F0 sequence; retire_cnt 0->1.
- rd=8'h21, end_sq only at LD4 -> LD0..LD4 in consecutive cycles, back to F0, retire_cnt+1. Repeat with rd=8'h30, end_sq=0 at ST4 -> illegal pulse, F0, no increment.
- rd=8'hFF, end_sq=1, pause_cc=1 -> HALT held 20 cycles, halted=1, retire_cnt unchanged; rst_n low -> R immediately.
- run=0 -> holds F0 with stopped=1; one step pulse -> exactly one MOV executes, then stopped=1 again; step during F1 ignored.
- rd=8'h70 -> ILL one cycle, illegal=1 one cycle, then F0. Separately, preload retire_cnt=16'hFFFF via 65535 MOVs (or force) -> next retire wraps to 0.
